// File: rtl/alu.sv
// Registered n-bit ALU: ripple-carry add/subtract, bitwise logic and single-position shifts.
// Result, carry-out and status flags are computed combinationally and captured on the clock edge.
module alu #(
    parameter int unsigned n = 32,
    parameter int unsigned m = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [m-1:0] sel,
    input  logic         cin,
    output logic [n-1:0] res,
    output logic         cout,
    output logic         flag_neg,
    output logic         flag_overflow,
    output logic         flag_null
);

    localparam logic [m-1:0] SelRca     = m'(0);
    localparam logic [m-1:0] SelRcs     = m'(1);
    localparam logic [m-1:0] SelAnd     = m'(2);
    localparam logic [m-1:0] SelOr      = m'(3);
    localparam logic [m-1:0] SelXor     = m'(4);
    localparam logic [m-1:0] SelShiftLs = m'(5);
    localparam logic [m-1:0] SelShiftLd = m'(6);
    localparam logic [m-1:0] SelShiftAs = m'(7);
    localparam logic [m-1:0] SelShiftAd = m'(8);

    logic         sub;
    logic [n-1:0] b_eff;
    logic [n:0]   carry;
    logic [n-1:0] sum;
    logic         add_ovf;

    logic [n-1:0] res_d, res_q;
    logic         cout_d, cout_q;
    logic         neg_d, neg_q;
    logic         ovf_d, ovf_q;
    logic         null_d, null_q;

    // Subtraction reuses the adder: a + ~b + !cin, so cout=1 means no borrow.
    assign sub      = (sel == SelRcs);
    assign b_eff    = sub ? ~b : b;
    assign carry[0] = sub ? ~cin : cin;

    for (genvar i = 0; i < n; i++) begin : g_rca
        assign sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign add_ovf = (a[n-1] == b_eff[n-1]) && (sum[n-1] != a[n-1]);

    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (sel)
            SelRca, SelRcs: begin
                res_d  = sum;
                cout_d = carry[n];
                ovf_d  = add_ovf;
            end
            SelAnd: res_d = a & b;
            SelOr:  res_d = a | b;
            SelXor: res_d = a ^ b;
            SelShiftLs: begin
                res_d  = {a[n-2:0], 1'b0};
                cout_d = a[n-1];
            end
            SelShiftLd: begin
                res_d  = {1'b0, a[n-1:1]};
                cout_d = a[0];
            end
            SelShiftAs: begin
                res_d  = {a[n-2:0], 1'b0};
                cout_d = a[n-1];
                ovf_d  = a[n-1] ^ a[n-2];
            end
            SelShiftAd: begin
                res_d  = {a[n-1], a[n-1:1]};
                cout_d = a[0];
            end
            default: begin
                res_d  = '0;
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end
        endcase
        neg_d  = res_d[n-1];
        null_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            null_q <= 1'b1;
        end else begin
            res_q  <= res_d;
            cout_q <= cout_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
            null_q <= null_d;
        end
    end

    assign res           = res_q;
    assign cout          = cout_q;
    assign flag_neg      = neg_q;
    assign flag_overflow = ovf_q;
    assign flag_null     = null_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases pinned to literal values, then random stimulus, all checked
// every cycle against an arithmetic reference model.
module tb_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        neg;
        logic        ovf;
        logic        nul;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  sel;
    logic        cin;
    logic [31:0] res;
    logic        cout, flag_neg, flag_overflow, flag_null;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b1;
    exp_t exp_next;

    alu #(.n(32), .m(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .sel          (sel),
        .cin          (cin),
        .res          (res),
        .cout         (cout),
        .flag_neg     (flag_neg),
        .flag_overflow(flag_overflow),
        .flag_null    (flag_null)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] fa, logic [31:0] fb, logic [3:0] fs,
                                   logic fc, logic frst_n);
        exp_t        e;
        logic [32:0] wide;
        longint      s;
        e = '0;
        if (frst_n) begin
            case (fs)
                4'd0: begin
                    wide   = {1'b0, fa} + {1'b0, fb} + 33'(fc);
                    e.res  = wide[31:0];
                    e.cout = wide[32];
                    s      = longint'($signed(fa)) + longint'($signed(fb)) + longint'(fc);
                    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                4'd1: begin
                    wide   = {1'b0, fa} + {1'b0, ~fb} + 33'(!fc);
                    e.res  = wide[31:0];
                    e.cout = wide[32];
                    s      = longint'($signed(fa)) - longint'($signed(fb)) - longint'(fc);
                    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                4'd2: e.res = fa & fb;
                4'd3: e.res = fa | fb;
                4'd4: e.res = fa ^ fb;
                4'd5, 4'd7: begin
                    e.res  = fa << 1;
                    e.cout = fa[31];
                    s      = longint'($signed(fa)) * 2;
                    if (fs == 4'd7)
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                4'd6: begin
                    e.res  = fa >> 1;
                    e.cout = fa[0];
                end
                4'd8: begin
                    e.res  = $unsigned($signed(fa) >>> 1);
                    e.cout = fa[0];
                end
                default: e.res = '0;
            endcase
        end
        e.neg = e.res[31];
        e.nul = (e.res == 32'd0);
        return e;
    endfunction

    function automatic void chk(string name, logic [35:0] act, logic [35:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Inputs change on the falling edge; the compare process checks one edge later.
    task automatic drive(logic [31:0] ta, logic [31:0] tb, logic [3:0] ts, logic tc,
                         logic trst_n);
        @(negedge clk);
        a        = ta;
        b        = tb;
        sel      = ts;
        cin      = tc;
        rst_n    = trst_n;
        exp_next = model(ta, tb, ts, tc, trst_n);
    endtask

    task automatic pin(string name, logic [31:0] r, logic c, logic ng, logic o, logic z);
        exp_t lit;
        lit = '{res: r, cout: c, neg: ng, ovf: o, nul: z};
        chk({"model ", name}, 36'(exp_next), 36'(lit));
    endtask

    always @(posedge clk) begin
        exp_t cur;
        cur = exp_next;
        #1;
        if (chk_en) begin
            chk("res", 36'(res), 36'(cur.res));
            chk("cout", 36'(cout), 36'(cur.cout));
            chk("flag_neg", 36'(flag_neg), 36'(cur.neg));
            chk("flag_overflow", 36'(flag_overflow), 36'(cur.ovf));
            chk("flag_null", 36'(flag_null), 36'(cur.nul));
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(($urandom_range(0, 1) << 31) | $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        a        = '0;
        b        = '0;
        sel      = '0;
        cin      = 1'b0;
        rst_n    = 1'b0;
        exp_next = model('0, '0, '0, 1'b0, 1'b0);
        pin("reset", 32'h0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("literal reset res", 36'(res), 36'd0);
        chk("literal reset null", 36'(flag_null), 36'd1);

        drive(32'd1, 32'd1, 4'd0, 0, 1);          pin("add 1+1", 32'd2, 0, 0, 0, 0);
        drive(32'h7FFF_FFFF, 32'd1, 4'd0, 0, 1);  pin("add ovf", 32'h8000_0000, 0, 1, 1, 0);
        drive(32'hFFFF_FFFF, 32'd1, 4'd0, 0, 1);  pin("add wrap", 32'h0, 1, 0, 0, 1);
        drive(32'd2, 32'd1, 4'd1, 0, 1);          pin("sub 2-1", 32'd1, 1, 0, 0, 0);
        drive(32'd0, 32'd1, 4'd1, 0, 1);          pin("sub 0-1", 32'hFFFF_FFFF, 0, 1, 0, 0);
        drive(32'h8000_0000, 32'd1, 4'd1, 0, 1);  pin("sub ovf", 32'h7FFF_FFFF, 1, 0, 1, 0);
        drive(32'd5, 32'd7, 4'd2, 1, 1);          pin("and", 32'd5, 0, 0, 0, 0);
        drive(32'd5, 32'd3, 4'd3, 1, 1);          pin("or", 32'd7, 0, 0, 0, 0);
        drive(32'd5, 32'd3, 4'd4, 0, 1);          pin("xor", 32'd6, 0, 0, 0, 0);
        drive(32'd5, 32'd5, 4'd4, 0, 1);          pin("xor self", 32'd0, 0, 0, 0, 1);
        drive(32'h8000_0002, 32'd0, 4'd5, 0, 1);  pin("shift ls", 32'h4, 1, 0, 0, 0);
        drive(32'h8000_0002, 32'd0, 4'd6, 0, 1);  pin("shift ld", 32'h4000_0001, 0, 0, 0, 0);
        drive(32'h8000_0002, 32'd0, 4'd7, 0, 1);  pin("shift as", 32'h4, 1, 0, 1, 0);
        drive(32'h8000_0002, 32'd0, 4'd8, 0, 1);  pin("shift ad", 32'hC000_0001, 0, 1, 0, 0);
        drive(32'd10, 32'd3, 4'd0, 1, 1);         pin("add cin", 32'd14, 0, 0, 0, 0);
        drive(32'd10, 32'd3, 4'd1, 1, 1);         pin("sub bin", 32'd6, 1, 0, 0, 0);
        drive(32'd100, 32'd23, 4'd0, 0, 0);       pin("reset mid", 32'h0, 0, 0, 0, 1);
        drive(32'h1234_5678, 32'hDEAD_BEEF, 4'd12, 1, 1);
        pin("reserved", 32'h0, 0, 0, 0, 1);

        for (int i = 0; i < 500; i++) begin
            drive(rand_operand(), rand_operand(), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered n-bit arithmetic/logic unit: ripple-carry add and subtract, bitwise AND/OR/XOR, and single-position logical/arithmetic shifts.
- Produces the result, carry-out and three status flags (negative, signed overflow, zero).
- Datapath leaf block; operands, operation select and carry-in come from the control unit.
- Outputs are captured on the clock edge.

Parameters:
- n, 32, operand/result width in bits (n ≥ 2).
- m, 4, width of the operation select.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- a  input  n  operand A.
- b  input  n  operand B; ignored by shift operations.
- sel  input  m  operation select (encoding below).
- cin  input  1  carry-in for RCA, borrow-in for RCS; ignored otherwise.
- res  output  n  registered result.
- cout  output  1  registered carry / shifted-out bit.
- flag_neg  output  1  registered res[n-1].
- flag_overflow  output  1  registered signed overflow.
- flag_null  output  1  registered (res == 0).

Behaviour:
- Reset is synchronous and active-low: on a rising clk edge with rst_n=0, res=0, cout=0, flag_neg=0, flag_overflow=0, flag_null=1.
- Reset overrides any operation in flight; the result of the cycle in which reset is sampled is discarded.
- Latency is one cycle, with no handshake. Inputs are sampled at rising edge k and the results are visible after edge k; a new operation is accepted every cycle.
- The core is combinational and registered at the output. Outputs hold their values while inputs are stable.
- sel encoding:
  - RCA=0: res = a + b + cin (mod 2^n); cout = carry out of bit n-1; overflow = (a[n-1]==b[n-1]) && (res[n-1]!=a[n-1]).
  - RCS=1: res = a - b - cin, computed as a + ~b + !cin. cout = carry out of that sum (1 = no borrow). Overflow = (a[n-1]!=b[n-1]) && (res[n-1]!=a[n-1]).
  - AND=2, OR=3, XOR=4: bitwise a op b; cout=0; overflow=0.
  - SHIFT_LS=5: res = {a[n-2:0],0}; cout = a[n-1]; overflow=0.
  - SHIFT_LD=6: res = {0,a[n-1:1]}; cout = a[0]; overflow=0.
  - SHIFT_AS=7: res = {a[n-2:0],0}; cout = a[n-1]; overflow = a[n-1]^a[n-2] (sign changed).
  - SHIFT_AD=8: res = {a[n-1],a[n-1:1]}; cout = a[0]; overflow=0.
  - 9..15 (reserved): res=0, cout=0, overflow=0.
- Flags for every sel: flag_neg = res[n-1]; flag_null = (res==0). Both are derived from the same-cycle result before registering.
- Arithmetic wraps modulo 2^n and carries are not sticky. All signed interpretation is two's complement.

Test Plan:
- Reset and add:
  - rst_n=0 for one edge -> res=0, cout=0, flag_null=1, other flags 0.
  - Release rst_n; a=1, b=1, sel=0, cin=0 -> one edge later res=2, cout=0, neg=0, ovf=0, null=0.
  - a=0x7FFFFFFF, b=1 -> res=0x80000000, neg=1, ovf=1, cout=0.
  - a=0xFFFFFFFF, b=1 -> res=0, cout=1, null=1, ovf=0.
- Subtract:
  - a=2, b=1, sel=1, cin=0 -> res=1, cout=1, ovf=0.
  - a=0, b=1 -> res=0xFFFFFFFF, cout=0, neg=1.
  - a=0x80000000, b=1 -> res=0x7FFFFFFF, ovf=1.
- Logic:
  - a=5, b=7, AND -> res=5.
  - a=5, b=3, OR -> res=7.
  - a=5, b=3, XOR -> res=6.
  - a=5, b=5, XOR -> res=0, null=1.
  - cout=0 and ovf=0 in all logic cases.
- Shifts, with a=0x80000002 and b=0:
  - SHIFT_LS -> res=0x00000004, cout=1.
  - SHIFT_LD -> res=0x40000001, cout=0.
  - SHIFT_AS -> res=0x00000004, cout=1, ovf=1.
  - SHIFT_AD -> res=0xC0000001, cout=0, neg=1.
- Back-to-back and reset mid-stream:
  - Change sel every cycle -> each result appears exactly one edge after its inputs.
  - Assert rst_n=0 alongside a valid ADD -> the reset values appear, not the sum.
- Reserved sel=12 with arbitrary a and b -> res=0, cout=0, ovf=0, null=1.
